// File: rtl/toggle_hs_responder_if.sv
// Bundle of the toggle-handshake request side and the valid/ready drain side
// of toggle_hs_responder. The initiator/consumer side uses the master modport,
// the responder uses the slave modport.
interface toggle_hs_responder_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              req_tgl;
    logic [DATA_W-1:0] req_data;
    logic              ack_tgl;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              evt_pulse;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    modport master (
        output req_tgl, req_data, out_ready,
        input  ack_tgl, out_valid, out_data, evt_pulse, level, overflow
    );

    modport slave (
        input  req_tgl, req_data, out_ready,
        output ack_tgl, out_valid, out_data, evt_pulse, level, overflow
    );
endinterface

// File: rtl/toggle_hs_responder.sv
// Receive side of a two-phase (toggle) handshake. Every level change of the
// asynchronous req_tgl is one request; its bundled req_data is captured into a
// small circular FIFO and acknowledged by toggling ack_tgl. When the FIFO is
// full the request is held pending (WAIT_SPACE) until a pop frees an entry.
module toggle_hs_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    toggle_hs_responder_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] DEPTH_L = PW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_WAIT_SPACE = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   req_edge_s;

    logic [DATA_W-1:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [PW-1:0]          wr_ptr_nxt_s;
    logic [PW-1:0]          rd_ptr_nxt_s;
    logic [PW-1:0]          level_r;
    logic [PW-1:0]          level_nxt_s;
    logic [AW-1:0]          wr_addr_s;
    logic [AW-1:0]          rd_addr_nxt_s;
    logic [DATA_W-1:0]      head_nxt_s;

    logic                   full_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   ovf_set_s;

    logic                   ack_r;
    logic                   out_valid_r;
    logic [DATA_W-1:0]      out_data_r;
    logic                   evt_r;
    logic                   overflow_r;

    // Synchronise req_tgl and keep the previous synchronised level for edge detection.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.req_tgl};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Any difference between the synchronised level and its previous value is one request.
    assign req_edge_s = sync_r[SYNC_STAGES-1] ^ prev_r;
    assign full_s     = (level_r == DEPTH_L);
    assign pop_s      = out_valid_r & bus.out_ready;

    // Request acceptance FSM: decide push, next state and overflow detection.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        ovf_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_edge_s) begin
                    if (!full_s) begin
                        push_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_SPACE;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_WAIT_SPACE: begin
                // Fullness is judged before this edge's pop, so a pop on a
                // full FIFO only frees the slot for the following edge.
                if (!full_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_SPACE;
                end
                // A second edge while one is pending is an initiator protocol
                // violation: flag it and drop it, the pending one is kept.
                if (req_edge_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    ovf_set_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pointer arithmetic and next registered FIFO head (with write-through bypass).
    always_comb begin
        wr_ptr_nxt_s  = wr_ptr_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        head_nxt_s    = out_data_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        level_nxt_s   = wr_ptr_nxt_s - rd_ptr_nxt_s;
        wr_addr_s     = wr_ptr_r[AW-1:0];
        rd_addr_nxt_s = rd_ptr_nxt_s[AW-1:0];
        // If the slot written this edge becomes the head, memory is not yet
        // updated, so forward the incoming payload directly.
        if (push_s && (wr_addr_s == rd_addr_nxt_s)) begin
            head_nxt_s = bus.req_data;
        end else begin
            head_nxt_s = mem_r[rd_addr_nxt_s];
        end
    end

    // FIFO storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (!clr && push_s) begin
            mem_r[wr_addr_s] <= bus.req_data;
        end
    end

    // State, pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            level_r     <= {PW{1'b0}};
            ack_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            evt_r       <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            ack_r       <= ack_r ^ push_s;
            out_valid_r <= (level_nxt_s != {PW{1'b0}});
            out_data_r  <= head_nxt_s;
            evt_r       <= push_s;
            overflow_r  <= overflow_r | ovf_set_s;
        end
    end

    assign bus.ack_tgl   = ack_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.evt_pulse = evt_r;
    assign bus.level     = level_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_toggle_hs_responder.sv
// Self-checking bench for toggle_hs_responder: table-driven directed sequences
// for reset, latency, fill/stall, overflow, simultaneous push/pop and reset
// mid-operation, then a randomized compliant initiator and random consumer
// checked against a queue-based reference of the request stream.
module tb_toggle_hs_responder;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int N_RAND      = 150;

    typedef struct {
        logic [7:0] data;
        logic       exp_ack;
        logic [2:0] exp_level;
    } fill_vec_t;

    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    fill_vec_t  fill_tab [4];
    logic [7:0] drain_tab [4];
    logic [7:0] expq [$];
    bit         prod_done;
    int         evt_cnt;

    always #5 clk = ~clk;

    toggle_hs_responder_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    toggle_hs_responder #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] d);
        bus.req_data = d;
        bus.req_tgl  = ~bus.req_tgl;
    endtask

    task automatic wait_ack(input string nm);
        logic prev;
        bit   seen;
        prev = bus.ack_tgl;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.ack_tgl !== prev) seen = 1'b1;
        end
        check(nm, 32'(seen), 32'h1);
    endtask

    task automatic do_reset();
        clr           = 1'b1;
        bus.req_tgl   = 1'b0;
        bus.req_data  = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic fill_four();
        for (int i = 0; i < 4; i++) begin
            send_req(fill_tab[i].data);
            wait_ack("fill_ack_seen");
            check("fill_ack",   32'(bus.ack_tgl),   32'(fill_tab[i].exp_ack));
            check("fill_level", 32'(bus.level),     32'(fill_tab[i].exp_level));
            check("fill_evt",   32'(bus.evt_pulse), 32'h1);
        end
    endtask

    // Random consumer side: pop checks against the request-order queue.
    task automatic consumer();
        for (int c = 0; c < 20000 && !(prod_done && expq.size() == 0); c++) begin
            @(negedge clk);
            if (bus.evt_pulse) evt_cnt++;
            check("rnd_level_max", 32'(bus.level <= 3'd4), 32'h1);
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_pop_unexpected: got %0h expected no data", bus.out_data);
                end else begin
                    check("rnd_pop_data", 32'(bus.out_data), 32'(expq[0]));
                    void'(expq.pop_front());
                end
            end
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b0;
    endtask

    // Random compliant initiator: toggles only after the previous ack.
    task automatic producer();
        int         gap;
        logic [7:0] d;
        for (int k = 0; k < N_RAND; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            d = 8'($urandom);
            expq.push_back(d);
            send_req(d);
            wait_ack("rnd_ack_seen");
            check("rnd_ack_parity", 32'(bus.ack_tgl), 32'((k + 1) & 1));
        end
        prod_done = 1'b1;
    endtask

    initial begin
        fill_tab[0] = '{data: 8'h01, exp_ack: 1'b1, exp_level: 3'd1};
        fill_tab[1] = '{data: 8'h02, exp_ack: 1'b0, exp_level: 3'd2};
        fill_tab[2] = '{data: 8'h03, exp_ack: 1'b1, exp_level: 3'd3};
        fill_tab[3] = '{data: 8'h04, exp_ack: 1'b0, exp_level: 3'd4};
        drain_tab[0] = 8'h02;
        drain_tab[1] = 8'h03;
        drain_tab[2] = 8'h04;
        drain_tab[3] = 8'h05;

        // 1. Reset state, out_ready while empty ignored
        do_reset();
        check("rst_ack",      32'(bus.ack_tgl),   32'h0);
        check("rst_valid",    32'(bus.out_valid), 32'h0);
        check("rst_level",    32'(bus.level),     32'h0);
        check("rst_overflow", 32'(bus.overflow),  32'h0);
        check("rst_evt",      32'(bus.evt_pulse), 32'h0);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("empty_pop_level", 32'(bus.level),     32'h0);
        check("empty_pop_valid", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // 2. Single request with exact latency
        send_req(8'hA5);
        tick();
        check("lat_e0_ack", 32'(bus.ack_tgl), 32'h0);
        tick();
        check("lat_e1_ack", 32'(bus.ack_tgl), 32'h0);
        check("lat_e1_evt", 32'(bus.evt_pulse), 32'h0);
        tick();
        check("lat_e2_ack",   32'(bus.ack_tgl),   32'h1);
        check("lat_e2_evt",   32'(bus.evt_pulse), 32'h1);
        check("lat_e2_valid", 32'(bus.out_valid), 32'h1);
        check("lat_e2_data",  32'(bus.out_data),  32'hA5);
        check("lat_e2_level", 32'(bus.level),     32'h1);
        tick();
        check("evt_one_cycle", 32'(bus.evt_pulse), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("single_pop_level", 32'(bus.level),     32'h0);
        check("single_pop_valid", 32'(bus.out_valid), 32'h0);

        // 3. Fill and stall
        do_reset();
        fill_four();
        send_req(8'h05);
        repeat (6) tick();
        check("stall_ack",   32'(bus.ack_tgl), 32'h0);
        check("stall_level", 32'(bus.level),   32'h4);

        // 4. Protocol violation while waiting for space
        bus.req_tgl = ~bus.req_tgl;
        repeat (4) tick();
        check("ovf_set", 32'(bus.overflow), 32'h1);
        check("ovf_no_ack", 32'(bus.ack_tgl), 32'h0);
        bus.out_ready = 1'b1;
        check("pop_head_01", 32'(bus.out_data), 32'h01);
        tick();
        bus.out_ready = 1'b0;
        check("pop_full_level", 32'(bus.level),   32'h3);
        check("pop_full_noack", 32'(bus.ack_tgl), 32'h0);
        tick();
        check("wait_push_ack",   32'(bus.ack_tgl),   32'h1);
        check("wait_push_level", 32'(bus.level),     32'h4);
        check("wait_push_evt",   32'(bus.evt_pulse), 32'h1);
        repeat (5) tick();
        check("single_pending_ack", 32'(bus.ack_tgl),  32'h1);
        check("ovf_sticky",         32'(bus.overflow), 32'h1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(bus.out_data), 32'(drain_tab[i]));
            tick();
        end
        bus.out_ready = 1'b0;
        check("drain_level",  32'(bus.level),     32'h0);
        check("drain_valid",  32'(bus.out_valid), 32'h0);
        check("drain_ovf",    32'(bus.overflow),  32'h1);

        // 5. Simultaneous push and pop
        do_reset();
        send_req(8'h10);
        wait_ack("sp_ack0");
        send_req(8'h11);
        wait_ack("sp_ack1");
        check("sp_level_pre", 32'(bus.level), 32'h2);
        send_req(8'h12);
        tick();
        tick();
        bus.out_ready = 1'b1;
        check("sp_head", 32'(bus.out_data), 32'h10);
        tick();
        bus.out_ready = 1'b0;
        check("sp_level", 32'(bus.level),   32'h2);
        check("sp_ack",   32'(bus.ack_tgl), 32'h1);
        check("sp_next0", 32'(bus.out_data), 32'h11);
        bus.out_ready = 1'b1;
        tick();
        check("sp_next1", 32'(bus.out_data), 32'h12);
        tick();
        bus.out_ready = 1'b0;
        check("sp_empty", 32'(bus.level), 32'h0);

        // 6. Reset during WAIT_SPACE with req_tgl held high
        do_reset();
        fill_four();
        send_req(8'h06);
        repeat (6) tick();
        check("r6_pre_ack",   32'(bus.ack_tgl), 32'h0);
        check("r6_pre_level", 32'(bus.level),   32'h4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("r6_ack",      32'(bus.ack_tgl),   32'h0);
        check("r6_valid",    32'(bus.out_valid), 32'h0);
        check("r6_level",    32'(bus.level),     32'h0);
        check("r6_overflow", 32'(bus.overflow),  32'h0);
        tick();
        tick();
        check("r6_e1_ack", 32'(bus.ack_tgl), 32'h0);
        tick();
        check("r6_e2_ack",   32'(bus.ack_tgl),  32'h1);
        check("r6_e2_level", 32'(bus.level),    32'h1);
        check("r6_e2_data",  32'(bus.out_data), 32'h06);
        repeat (5) tick();
        check("r6_once_ack",   32'(bus.ack_tgl), 32'h1);
        check("r6_once_level", 32'(bus.level),   32'h1);

        // 7. Randomized traffic
        do_reset();
        expq.delete();
        prod_done = 1'b0;
        evt_cnt   = 0;
        fork
            producer();
            consumer();
        join
        tick();
        check("rnd_final_ack",   32'(bus.ack_tgl),   32'(N_RAND & 1));
        check("rnd_final_level", 32'(bus.level),     32'h0);
        check("rnd_final_valid", 32'(bus.out_valid), 32'h0);
        check("rnd_final_ovf",   32'(bus.overflow),  32'h0);
        check("rnd_evt_count",   32'(evt_cnt),       32'(N_RAND));
        check("rnd_queue_empty", 32'(expq.size()),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
